// File: rtl/axis_tsn_tx_arbiter.sv
// axis_tsn_tx_arbiter: frame-level arbiter merging critical and best-effort byte streams onto one AXIS output
module axis_tsn_tx_arbiter #(
  parameter int CRIT_BURST_MAX = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 axis_aclk,
  input  logic                 rst,
  input  logic                 s_crit_tvalid,
  output logic                 s_crit_tready,
  input  logic [7:0]           s_crit_tdata,
  input  logic                 s_crit_tlast,
  input  logic                 s_be_tvalid,
  output logic                 s_be_tready,
  input  logic [7:0]           s_be_tdata,
  input  logic                 s_be_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tlast,
  input  logic                 gate_crit_open,
  input  logic                 gate_be_open,
  output logic [1:0]           grant,
  output logic [CNT_WIDTH-1:0] crit_frame_cnt,
  output logic [CNT_WIDTH-1:0] be_frame_cnt
);
  localparam int SW = $clog2(CRIT_BURST_MAX + 1) + 1;
  localparam logic [SW-1:0] L_MAX = SW'(CRIT_BURST_MAX);
  typedef enum logic [1:0] {IDLE = 2'b00, CRIT = 2'b01, BE = 2'b10} state_t;
  state_t r_state;
  logic [SW-1:0] r_streak;
  logic [CNT_WIDTH-1:0] r_crit_cnt, r_be_cnt;
  logic w_crit_ok, w_be_ok, w_force_be, w_in_crit, w_in_be, w_end;
  assign w_crit_ok = s_crit_tvalid & gate_crit_open;
  assign w_be_ok = s_be_tvalid & gate_be_open;
  assign w_force_be = w_crit_ok & w_be_ok & (CRIT_BURST_MAX != 0) & (r_streak == L_MAX);
  assign w_in_crit = (r_state == CRIT);
  assign w_in_be = (r_state == BE);
  assign w_end = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign grant = r_state;
  assign crit_frame_cnt = r_crit_cnt;
  assign be_frame_cnt = r_be_cnt;
  // zero-latency pass-through of the granted stream; nothing flows while idle
  always_comb begin
    m_axis_tvalid = w_in_crit ? s_crit_tvalid : w_in_be ? s_be_tvalid : 1'b0;
    m_axis_tdata = w_in_crit ? s_crit_tdata : w_in_be ? s_be_tdata : 8'h00;
    m_axis_tlast = w_in_crit ? s_crit_tlast : w_in_be ? s_be_tlast : 1'b0;
    s_crit_tready = w_in_crit & m_axis_tready;
    s_be_tready = w_in_be & m_axis_tready;
  end
  // frame-boundary arbitration with a bounded critical streak, plus per-class frame counting
  always_ff @(posedge axis_aclk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_streak <= '0;
      r_crit_cnt <= '0;
      r_be_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_force_be) begin
            r_state <= BE;
            r_streak <= '0;
          end else if (w_crit_ok) begin
            r_state <= CRIT;
            if (w_be_ok && r_streak != L_MAX) r_streak <= r_streak + 1'b1;
          end else if (w_be_ok) begin
            r_state <= BE;
            r_streak <= '0;
          end
        end
        CRIT: if (w_end) begin
          r_state <= IDLE;
          r_crit_cnt <= r_crit_cnt + 1'b1;
        end
        BE: if (w_end) begin
          r_state <= IDLE;
          r_be_cnt <= r_be_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_tsn_tx_arbiter.sv
// tb_axis_tsn_tx_arbiter: directed and randomized frame traffic checked against a queue-based reference
module tb_axis_tsn_tx_arbiter;
  localparam int BURST = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic cv = 1'b0, cr, cl = 1'b0, bv = 1'b0, br, bl = 1'b0, mv, mr = 1'b1, ml, gc = 1'b1, gb = 1'b1;
  logic [7:0] cd = 8'h00, bd = 8'h00, md;
  logic [1:0] grant;
  logic [15:0] ccnt, bcnt;
  logic cv1 = 1'b0, cr1, bv1 = 1'b0, br1, mv1, ml1;
  logic [7:0] md1;
  logic [1:0] grant1;
  logic [3:0] ccnt1, bcnt1;
  logic [8:0] src_c[$], src_b[$], exp_c[$], exp_b[$];
  bit out_cls_q[$];
  int nvec = 0, nerr = 0;
  int nfc, nfb, out_bytes, gc_cycles, tot_c, tot_b, n1_c, n1_b;
  bit in_frame, cur, gaps, rnd, en1;

  always #5 clk = ~clk;

  axis_tsn_tx_arbiter #(.CRIT_BURST_MAX(BURST), .CNT_WIDTH(16)) u_dut (
    .axis_aclk(clk), .rst(rst),
    .s_crit_tvalid(cv), .s_crit_tready(cr), .s_crit_tdata(cd), .s_crit_tlast(cl),
    .s_be_tvalid(bv), .s_be_tready(br), .s_be_tdata(bd), .s_be_tlast(bl),
    .m_axis_tvalid(mv), .m_axis_tready(mr), .m_axis_tdata(md), .m_axis_tlast(ml),
    .gate_crit_open(gc), .gate_be_open(gb), .grant(grant),
    .crit_frame_cnt(ccnt), .be_frame_cnt(bcnt)
  );

  axis_tsn_tx_arbiter #(.CRIT_BURST_MAX(0), .CNT_WIDTH(4)) u_dut1 (
    .axis_aclk(clk), .rst(rst),
    .s_crit_tvalid(cv1), .s_crit_tready(cr1), .s_crit_tdata(8'h11), .s_crit_tlast(1'b1),
    .s_be_tvalid(bv1), .s_be_tready(br1), .s_be_tdata(8'h22), .s_be_tlast(1'b1),
    .m_axis_tvalid(mv1), .m_axis_tready(1'b1), .m_axis_tdata(md1), .m_axis_tlast(ml1),
    .gate_crit_open(1'b1), .gate_be_open(1'b1), .grant(grant1),
    .crit_frame_cnt(ccnt1), .be_frame_cnt(bcnt1)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(bit cls, int len);
    logic [8:0] w;
    for (int i = 0; i < len; i++) begin
      w = {i == len - 1, cls, 7'($urandom)};
      if (cls) begin src_b.push_back(w); exp_b.push_back(w); end
      else begin src_c.push_back(w); exp_c.push_back(w); end
    end
    if (cls) tot_b++; else tot_c++;
  endtask

  task automatic cycle();
    logic c_hs, b_hs, have, fin;
    logic [8:0] e;
    @(negedge clk);
    c_hs = cv & cr;
    b_hs = bv & br;
    if (grant === 2'b01) gc_cycles++;
    if (mv1 === 1'b1 && grant1 === 2'b01) n1_c++;
    if (mv1 === 1'b1 && grant1 === 2'b10) n1_b++;
    if (mv === 1'b1 && mr) begin
      if (!in_frame) begin cur = md[7]; in_frame = 1; end
      have = cur ? exp_b.size() > 0 : exp_c.size() > 0;
      chk("beat_expected", have, 1);
      e = 9'h000;
      if (have) e = cur ? exp_b.pop_front() : exp_c.pop_front();
      chk("beat_data", {ml, md}, e);
      chk("beat_grant", grant, cur ? 2 : 1);
      out_bytes++;
      fin = have ? e[8] : ml;
      if (fin) begin
        in_frame = 0;
        out_cls_q.push_back(cur);
        if (cur) nfb++; else nfc++;
      end
    end
    @(posedge clk);
    #1;
    if (c_hs) void'(src_c.pop_front());
    if (b_hs) void'(src_b.pop_front());
    if (!cv || c_hs) cv = src_c.size() > 0 && (!gaps || $urandom_range(0, 3) != 0);
    if (!bv || b_hs) bv = src_b.size() > 0 && (!gaps || $urandom_range(0, 3) != 0);
    if (src_c.size() > 0) {cl, cd} = src_c[0];
    if (src_b.size() > 0) {bl, bd} = src_b[0];
    mr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    cv1 = en1 && (n1_c + n1_b < 17);
    bv1 = cv1;
  endtask

  task automatic reset_all();
    rst = 1;
    cv = 0; bv = 0; cv1 = 0; bv1 = 0; en1 = 0;
    src_c.delete(); src_b.delete(); exp_c.delete(); exp_b.delete(); out_cls_q.delete();
    nfc = 0; nfb = 0; out_bytes = 0; gc_cycles = 0; tot_c = 0; tot_b = 0; n1_c = 0; n1_b = 0; in_frame = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic run_frames(int n, int bound);
    int k = 0;
    while (nfc + nfb < n && k < bound) begin cycle(); k++; end
    chk("frames_done", nfc + nfb, n);
  endtask

  initial begin
    int k, ec;
    gaps = 0; rnd = 0; en1 = 0;
    #3 rst = 1;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_crit_cnt", ccnt, 0);
    chk("rst_be_cnt", bcnt, 0);
    chk("rst_crit_tready", cr, 0);
    chk("rst_be_tready", br, 0);
    chk("rst_m_tvalid", mv, 0);
    chk("rst_grant1", grant1, 0);
    reset_all();
    push_frame(0, 64);
    run_frames(1, 200);
    chk("t1_idle_grant", grant, 0);
    chk("t1_crit_cnt", ccnt, 1);
    chk("t1_be_cnt", bcnt, 0);
    chk("t1_grant_cycles", gc_cycles, 64);
    chk("t1_bytes", out_bytes, 64);
    reset_all();
    for (int i = 0; i < 10; i++) begin
      push_frame(0, $urandom_range(1, 8));
      push_frame(1, $urandom_range(1, 8));
    end
    run_frames(10, 400);
    ec = 0;
    for (int i = 0; i < 10; i++) begin
      chk("t2_order", out_cls_q[i], (i % (BURST + 1)) == BURST);
      if ((i % (BURST + 1)) != BURST) ec++;
    end
    chk("t2_crit_cnt", ccnt, ec);
    chk("t2_be_cnt", bcnt, 10 - ec);
    reset_all();
    gc = 0; gb = 0;
    push_frame(0, 10);
    push_frame(1, 100);
    repeat (5) cycle();
    chk("t4_closed_tvalid", mv, 0);
    chk("t4_closed_grant", grant, 0);
    chk("t4_closed_crit_tready", cr, 0);
    chk("t4_closed_be_tready", br, 0);
    gb = 1;
    cycle();
    chk("t4_be_selected", grant, 2'b10);
    repeat (10) cycle();
    gb = 0;
    run_frames(1, 300);
    chk("t4_be_cnt", bcnt, 1);
    chk("t4_crit_cnt", ccnt, 0);
    chk("t4_bytes", out_bytes, 100);
    repeat (3) cycle();
    chk("t4_idle_after", grant, 0);
    chk("t4_idle_tvalid", mv, 0);
    reset_all();
    gc = 1; gb = 1; gaps = 1; rnd = 1;
    for (int i = 0; i < 200; i++) push_frame(1'($urandom_range(0, 1)), $urandom_range(1, 20));
    run_frames(200, 40000);
    chk("t5_crit_cnt", ccnt, tot_c);
    chk("t5_be_cnt", bcnt, tot_b);
    chk("t5_crit_left", exp_c.size(), 0);
    chk("t5_be_left", exp_b.size(), 0);
    gaps = 0; rnd = 0;
    reset_all();
    push_frame(0, 64);
    k = 0;
    while (out_bytes < 30 && k < 200) begin cycle(); k++; end
    chk("t6_bytes_before_rst", out_bytes, 30);
    chk("t6_mid_grant", grant, 2'b01);
    #2 rst = 1;
    #1;
    chk("t6_async_grant", grant, 0);
    chk("t6_async_crit_cnt", ccnt, 0);
    chk("t6_async_crit_tready", cr, 0);
    chk("t6_async_tvalid", mv, 0);
    reset_all();
    push_frame(1, 5);
    run_frames(1, 100);
    chk("t6_after_be_cnt", bcnt, 1);
    chk("t6_after_crit_cnt", ccnt, 0);
    chk("t6_after_class", out_cls_q[0], 1);
    reset_all();
    en1 = 1;
    k = 0;
    while (n1_c + n1_b < 17 && k < 200) begin cycle(); k++; end
    chk("t7_frames", n1_c + n1_b, 17);
    chk("t7_strict_no_be", n1_b, 0);
    chk("t7_crit_wrap", ccnt1, n1_c % 16);
    chk("t7_be_cnt", bcnt1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
